// File: rtl/sram_req_adapter_pkg.sv
// Shared defaults and request-type encoding for the SRAM request adapter.
package sram_req_adapter_pkg;

    localparam int BITS_DEFAULT       = 128;
    localparam int ADDR_W_DEFAULT     = 6;
    localparam int RESP_DEPTH_DEFAULT = 2;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

endpackage

// File: rtl/sram_req_adapter_resp_fifo.sv
// Read-response buffer: DEPTH-entry circular FIFO with occupancy count.
module resp_fifo
    import sram_req_adapter_pkg::*;
#(
    parameter  int WIDTH = BITS_DEFAULT,
    parameter  int DEPTH = RESP_DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             pop_ok;
    logic             push_ok;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != CNT_W'(DEPTH)) || pop_ok);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wrap_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= wrap_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready request port to single-port SRAM macro with an in-order,
// back-pressured read-response buffer.
module sram_req_adapter
    import sram_req_adapter_pkg::*;
#(
    parameter int BITS       = BITS_DEFAULT,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int RESP_DEPTH = RESP_DEPTH_DEFAULT
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BITS-1:0]   req_wdata,
    input  logic [BITS-1:0]   req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [BITS-1:0]   resp_rdata,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [BITS-1:0]   sram_bwen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [BITS-1:0]   sram_d,
    input  logic [BITS-1:0]   sram_q
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    req_type_e         req_type;
    logic              accept;
    logic              acc_wr;
    logic              acc_rd;
    logic              pop;
    logic              rd_room;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              rd_vld_p1;
    logic [ADDR_W-1:0] addr_hold;
    logic [BITS-1:0]   data_hold;

    assign req_type = req_type_e'(req_write);
    assign pop      = resp_valid && resp_ready;

    // Count the word already in flight so it always has a slot when it lands.
    assign occupancy = (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop) + (CNT_W+1)'(rd_vld_p1);
    assign rd_room   = occupancy < (CNT_W+1)'(RESP_DEPTH);

    assign req_ready = RSTN && ((req_type == REQ_WRITE) || rd_room);
    assign accept    = req_valid && req_ready;
    assign acc_wr    = accept && (req_type == REQ_WRITE);
    assign acc_rd    = accept && (req_type == REQ_READ);

    always_comb begin
        sram_cen  = ~accept;
        sram_wen  = ~acc_wr;
        sram_bwen = acc_wr ? ~req_wmask : '1;
        sram_a    = accept ? req_addr : addr_hold;
        sram_d    = acc_wr ? req_wdata : data_hold;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_vld_p1 <= 1'b0;
            addr_hold <= '0;
            data_hold <= '0;
        end else begin
            rd_vld_p1 <= acc_rd;
            if (accept) addr_hold <= req_addr;
            if (acc_wr) data_hold <= req_wdata;
        end
    end

    // p1: the macro presents read data; capture it only on this cycle.
    resp_fifo #(
        .WIDTH (BITS),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (rd_vld_p1),
        .wdata (sram_q),
        .pop   (pop),
        .rdata (resp_rdata),
        .count (fifo_count)
    );

    assign resp_valid = (fifo_count != '0);

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter with a behavioural SRAM macro model.
module tb_sram_req_adapter;

    localparam int BITS   = 128;
    localparam int ADDR_W = 6;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [BITS-1:0]   req_wdata;
    logic [BITS-1:0]   req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [BITS-1:0]   resp_rdata;
    logic              sram_cen;
    logic              sram_wen;
    logic [BITS-1:0]   sram_bwen;
    logic [ADDR_W-1:0] sram_a;
    logic [BITS-1:0]   sram_d;
    logic [BITS-1:0]   sram_q;

    sram_req_adapter #(.BITS(BITS), .ADDR_W(ADDR_W), .RESP_DEPTH(2)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_bwen  (sram_bwen),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    always #5 CLK = ~CLK;

    // Macro model: q valid only the cycle after a read, garbage otherwise.
    logic [BITS-1:0] mem [64];
    logic [BITS-1:0] q_reg = '0;
    logic [BITS-1:0] junk  = '0;
    logic            cap   = 1'b0;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    always @(posedge CLK) begin
        junk <= {$urandom, $urandom, $urandom, $urandom};
        cap  <= !sram_cen && sram_wen;
        if (!sram_cen && sram_wen) q_reg <= mem[sram_a];
        if (!sram_cen && !sram_wen) mem[sram_a] <= (mem[sram_a] & sram_bwen) | (sram_d & ~sram_bwen);
    end
    assign sram_q = cap ? q_reg : junk;

    logic [BITS-1:0] got[$];
    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] shadow [64];
    int checks   = 0;
    int failures = 0;

    always @(negedge CLK) begin
        if (RSTN && resp_valid && resp_ready) got.push_back(resp_rdata);
    end

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [BITS-1:0]   wdata;
        logic [BITS-1:0]   wmask;
        logic [BITS-1:0]   exp_rdata;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        tick();
        req_valid = 1'b0;
    endtask

    // Presents a request and waits (bounded) until it is accepted at the next edge.
    task automatic send(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [BITS-1:0] data, input logic [BITS-1:0] mask,
                        output logic rdy0);
        int guard;
        tick();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        #1;
        rdy0  = req_ready;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge CLK);
            #2;
            guard++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=req_ready_low required=accept addr=%0d", addr);
        end else if (wr) begin
            shadow[addr] = (shadow[addr] & ~mask) | (data & mask);
        end else begin
            exp_q.push_back(shadow[addr]);
        end
    endtask

    task automatic wait_got(input int n, input string name);
        int guard = 0;
        while (got.size() < n && guard < 300) begin
            @(posedge CLK);
            guard++;
        end
        #2;
        if (got.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, got.size(), n);
        end
    endtask

    task automatic compare_queues(input string name);
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_count actual=%0d required=%0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) check(name, got[i], exp_q[i]);
    endtask

    initial begin
        logic rdy;
        logic [BITS-1:0] ones;
        logic [BITS-1:0] rd_data;
        ones = '1;
        for (int i = 0; i < 64; i++) shadow[i] = '0;

        tbl[0] = '{1'b1, 6'd5,  128'hDEAD, ones, '0};
        tbl[1] = '{1'b0, 6'd5,  '0, '0, 128'hDEAD};
        tbl[2] = '{1'b1, 6'd3,  ones, ones, '0};
        tbl[3] = '{1'b1, 6'd3,  '0, 128'h00FF, '0};
        tbl[4] = '{1'b0, 6'd3,  '0, '0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00};
        tbl[5] = '{1'b1, 6'd63, 128'h12345678, ones, '0};
        tbl[6] = '{1'b1, 6'd63, 128'hABCD0000, 128'hFFFF0000, '0};
        tbl[7] = '{1'b0, 6'd63, '0, '0, 128'hABCD5678};
        tbl[8] = '{1'b1, 6'd0,  128'h01234567_89ABCDEF_FEDCBA98_76543210,
                   128'hFFFFFFFF_FFFFFFFF_00000000_00000000, '0};
        tbl[9] = '{1'b0, 6'd0,  '0, '0, 128'h01234567_89ABCDEF_00000000_00000000};

        // Reset with a write request pending: macro must stay idle.
        RSTN       = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 6'd7;
        req_wdata  = ones;
        req_wmask  = ones;
        resp_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        check1("rst_cen", sram_cen, 1'b1);
        check1("rst_wen", sram_wen, 1'b1);
        check("rst_bwen", sram_bwen, ones);
        check("rst_a", BITS'(sram_a), '0);
        check("rst_d", sram_d, '0);
        check1("rst_resp_valid", resp_valid, 1'b0);
        req_valid = 1'b0;
        RSTN      = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            req_valid = 1'b1;
            req_write = tbl[i].wr;
            req_addr  = tbl[i].addr;
            req_wdata = tbl[i].wdata;
            req_wmask = tbl[i].wmask;
            #1;
            check1("vec_ready", req_ready, 1'b1);
            check1("vec_cen", sram_cen, 1'b0);
            check1("vec_wen", sram_wen, !tbl[i].wr);
            check("vec_bwen", sram_bwen, tbl[i].wr ? ~tbl[i].wmask : ones);
            check("vec_a", BITS'(sram_a), BITS'(tbl[i].addr));
            if (tbl[i].wr) check("vec_d", sram_d, tbl[i].wdata);
            idle();
            #1;
            check1("vec_cen_idle", sram_cen, 1'b1);
            if (!tbl[i].wr) begin
                check1("vec_lat1_valid", resp_valid, 1'b0);
                tick();
                #1;
                check1("vec_lat2_valid", resp_valid, 1'b1);
                check("vec_rdata", resp_rdata, tbl[i].exp_rdata);
            end
        end
        tick();
        #1;
        check("hold_a", BITS'(sram_a), BITS'(6'd0));
        check("hold_d", sram_d, tbl[8].wdata);
        check1("drained", resp_valid, 1'b0);

        // Back-pressure: third read must stall until a pop frees a slot.
        for (int i = 0; i < 64; i++) shadow[i] = mem[i];
        resp_ready = 1'b0;
        send(1'b1, 6'd1, 128'h11, ones, rdy);
        send(1'b1, 6'd2, 128'h22, ones, rdy);
        send(1'b1, 6'd3, 128'h33, ones, rdy);
        got.delete();
        exp_q.delete();
        send(1'b0, 6'd1, '0, '0, rdy);
        check1("bp_rd1_ready", rdy, 1'b1);
        send(1'b0, 6'd2, '0, '0, rdy);
        check1("bp_rd2_ready", rdy, 1'b1);
        tick();
        req_addr = 6'd3;
        #1;
        check1("bp_rd3_stall0", req_ready, 1'b0);
        check1("bp_rd3_cen", sram_cen, 1'b1);
        tick();
        #1;
        check1("bp_rd3_stall1", req_ready, 1'b0);
        tick();
        #1;
        check1("bp_rd3_stall2", req_ready, 1'b0);
        resp_ready = 1'b1;
        #1;
        check1("bp_rd3_ready_on_pop", req_ready, 1'b1);
        check("bp_head", resp_rdata, 128'h11);
        exp_q.push_back(128'h33);
        idle();
        wait_got(3, "bp");
        compare_queues("bp_order");

        // Streaming reads of the whole array with the consumer always ready.
        for (int i = 0; i < 64; i++)
            send(1'b1, 6'(i), {32'(i) ^ 32'hA5A5A5A5, 64'h0, 32'(i)}, ones, rdy);
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            send(1'b0, 6'(i), '0, '0, rdy);
            check1("stream_ready", rdy, 1'b1);
        end
        idle();
        wait_got(64, "stream");
        compare_queues("stream_data");

        // Random idle gaps and writes; sram_q is garbage on every non-capture cycle.
        got.delete();
        exp_q.delete();
        for (int n = 0; n < 32; n++) begin
            repeat ($urandom_range(3)) idle();
            rd_data = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(1) == 1)
                send(1'b1, 6'($urandom_range(7)), rd_data, {$urandom, $urandom, $urandom, $urandom}, rdy);
            else
                send(1'b0, 6'($urandom_range(7)), '0, '0, rdy);
        end
        idle();
        wait_got(exp_q.size(), "rand");
        compare_queues("rand_data");

        // Reset one cycle after a read accept with another response buffered.
        resp_ready = 1'b0;
        send(1'b0, 6'd1, '0, '0, rdy);
        send(1'b0, 6'd2, '0, '0, rdy);
        idle();
        #1;
        check1("pre_rst_buffered", resp_valid, 1'b1);
        RSTN = 1'b0;
        #1;
        check1("mid_rst_cen", sram_cen, 1'b1);
        check1("mid_rst_valid", resp_valid, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        check1("mid_rst_cen_hold", sram_cen, 1'b1);
        RSTN = 1'b1;
        got.delete();
        exp_q.delete();
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            check1("post_rst_no_resp", resp_valid, 1'b0);
        end
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL post_rst_popped actual=%0d required=0", got.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
